// File: rtl/alu_pipe_if.sv
// alu_pipe handshake bundle: operand/op request
// channel and result/flag response channel.
interface alu_pipe_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output overflow
  );

endinterface

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: logic/arith/shift ops in one
// cycle, shift-add MUL over WIDTH cycles, valid/ready I/O.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [SW-1:0] LAST =
    SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic             w_d_and;
  logic             w_d_or;
  logic             w_d_add;
  logic             w_d_sub;
  logic             w_d_slt;
  logic             w_d_sll;
  logic             w_d_srl;
  logic             w_d_sra;
  logic             w_d_nor;
  logic             w_is_mul;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_sv;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_acc_nx;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_d_and = (bus.op == OP_AND);
  assign w_d_or  = (bus.op == OP_OR);
  assign w_d_add = (bus.op == OP_ADD);
  assign w_d_sub = (bus.op == OP_SUB);
  assign w_d_slt = (bus.op == OP_SLT);
  assign w_d_sll = (bus.op == OP_SLL);
  assign w_d_srl = (bus.op == OP_SRL);
  assign w_d_sra = (bus.op == OP_SRA);
  assign w_d_nor = (bus.op == OP_NOR);

  // with MUL disabled the code decodes as undefined
  assign w_is_mul = (MUL_EN != 0)
                  && (bus.op == OP_MUL);

  // SLT reuses the subtractor: a + ~b + 1
  assign w_neg_b = w_d_sub || w_d_slt;
  assign w_bx    = w_neg_b ? ~bus.b : bus.b;
  assign w_sum   = bus.a + w_bx
                 + WIDTH'(w_neg_b);

  assign w_sv = (bus.a[MSB] == w_bx[MSB])
             && (w_sum[MSB] != bus.a[MSB]);

  assign w_sh = bus.b[SW-1:0];

  assign w_acc_nx = r_mplier[0]
                  ? r_acc + r_mcand
                  : r_acc;

  assign w_out_xfer = r_out_valid
                   && bus.out_ready;
  assign w_in_ready = (r_state == S_IDLE)
                   && (!r_out_valid
                       || bus.out_ready);
  assign w_in_xfer  = bus.in_valid
                   && w_in_ready;

  // single-cycle result and overflow select
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (1'b1)
      w_d_and: w_res = bus.a & bus.b;
      w_d_or:  w_res = bus.a | bus.b;
      w_d_add: begin
        w_res = w_sum;
        w_ovf = w_sv;
      end
      w_d_sub: begin
        w_res = w_sum;
        w_ovf = w_sv;
      end
      w_d_slt: begin
        w_res = WIDTH'(w_sum[MSB] ^ w_sv);
      end
      w_d_sll: w_res = bus.a << w_sh;
      w_d_srl: w_res = bus.a >> w_sh;
      w_d_sra: begin
        w_res = $unsigned(
          $signed(bus.a) >>> w_sh);
      end
      w_d_nor: w_res = ~(bus.a | bus.b);
      default: w_res = '0;
    endcase
  end

  // control FSM plus registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
          end
          if (w_in_xfer && w_is_mul) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end else if (w_in_xfer) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result    <= w_acc_nx;
            r_zero      <= (w_acc_nx == '0);
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed plan
// steps followed by randomized traffic vs a reference model.
module tb_alu_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(
    .WIDTH (W),
    .MUL_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  // reference: {result, zero, overflow} from plain arithmetic
  function automatic logic [33:0] model(
      input logic [3:0]  op,
      input logic [31:0] a,
      input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic v;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = '0;
    v = 1'b0;
    s = 0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = sa + sb;
        r = 32'(s);
        v = (s != longint'($signed(r)));
      end
      4'b0110: begin
        s = sa - sb;
        r = 32'(s);
        v = (s != longint'($signed(r)));
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      4'b1010: r = 32'(sa >>> sh);
      4'b1011: r = 32'(64'(a) * 64'(b));
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), v};
  endfunction

  function automatic logic [33:0] obs_bus();
    return {bus.result, bus.zero,
            bus.overflow};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200)
      check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [3:0]  op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic op1(input string tag,
                     input logic [3:0]  op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [33:0] exp);
    send(op, a, b);
    check({tag, "_ov"},
          64'(bus.out_valid), 64'd1);
    check(tag, 64'(obs_bus()), 64'(exp));
  endtask

  // waits for a MUL result; returns edges since accept
  task automatic run_mul(input logic [31:0] a,
                         input logic [31:0] b,
                         output int lat,
                         output bit ir_seen);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.op = 4'b1011;
    bus.a  = a;
    bus.b  = b;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    ir_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ir_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  logic [33:0] expq[$];
  logic [33:0] exp_v;
  logic [33:0] prev;
  logic [31:0] hold_r;
  logic [3:0]  rop;
  int          lat;
  int          sent;
  int          cyc;
  bit          ir_seen;
  bit          bad;
  bit          bad_bp;
  bit          bad_stab;
  bit          stalled;

  initial begin
    bus.in_valid  = 1'b1;
    bus.op        = 4'b0010;
    bus.a         = 32'd1;
    bus.b         = 32'd1;
    bus.out_ready = 1'b0;

    // reset wins over a presented op
    tick();
    tick();
    check("rst_ov", 64'(bus.out_valid), 64'd0);
    check("rst_flags", 64'(obs_bus()),
          64'({32'd0, 1'b1, 1'b0}));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("rst_noacc", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;

    // arithmetic and flags
    op1("add_ovf", 4'b0010, 32'h7FFF_FFFF,
        32'd1, {32'h8000_0000, 1'b0, 1'b1});
    op1("sub_zero", 4'b0110, 32'd5, 32'd5,
        {32'd0, 1'b1, 1'b0});
    op1("slt_neg", 4'b0111, 32'h8000_0000,
        32'd1, {32'd1, 1'b0, 1'b0});
    op1("slt_ovf", 4'b0111, 32'h7FFF_FFFF,
        32'hFFFF_FFFF, {32'd0, 1'b1, 1'b0});

    // shifts and undefined op
    op1("sll", 4'b1000, 32'h8000_0010,
        32'h24, {32'h0000_0100, 1'b0, 1'b0});
    op1("srl", 4'b1001, 32'h8000_0010,
        32'd4, {32'h0800_0001, 1'b0, 1'b0});
    op1("sra", 4'b1010, 32'h8000_0010,
        32'd4, {32'hF800_0001, 1'b0, 1'b0});
    op1("undef", 4'b1111, 32'h1234,
        32'h5678, {32'd0, 1'b1, 1'b0});
    op1("nor", 4'b1100, 32'hF0F0_0000,
        32'h0000_0F0F, {32'h0F0F_F0F0, 1'b0, 1'b0});

    // multiplier latency, in_ready, hold
    tick();
    bus.out_ready = 1'b0;
    run_mul(32'h0001_2345, 32'h100, lat, ir_seen);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_ir_busy", 64'(ir_seen), 64'd0);
    check("mul_res", 64'(obs_bus()),
          64'({32'h0123_4500, 1'b0, 1'b0}));
    tick();
    tick();
    check("mul_hold_ir", 64'(bus.in_ready), 64'd0);
    check("mul_hold_ov", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("mul_taken_ov", 64'(bus.out_valid), 64'd0);
    check("mul_taken_ir", 64'(bus.in_ready), 64'd1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF,
            lat, ir_seen);
    check("mul_ones", 64'(obs_bus()),
          64'({32'd1, 1'b0, 1'b0}));
    tick();

    // back-pressure with a pending AND result
    bus.out_ready = 1'b0;
    send(4'b0000, 32'hF0F0, 32'hFF00);
    hold_r = 32'h0000_F000;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready) bad = 1'b1;
      if (bus.result !== hold_r) bad = 1'b1;
      if (!bus.out_valid) bad = 1'b1;
      tick();
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_res", 64'(bus.result), 64'(hold_r));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op = 4'b0001;
    bus.a  = 32'hF0;
    bus.b  = 32'h0F;
    #1;
    check("bp_rel_ir", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_rel_ov", 64'(bus.out_valid), 64'd1);
    check("bp_rel_res", 64'(bus.result), 64'hFF);
    tick();

    // reset in the middle of a MUL
    send(4'b1011, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_ir", 64'(bus.in_ready), 64'd1);
    check("mrst_flags",
          64'({bus.out_valid, obs_bus()}),
          64'({1'b0, 32'd0, 1'b1, 1'b0}));
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) bad = 1'b1;
      tick();
    end
    check("mrst_noout", 64'(bad), 64'd0);
    op1("mrst_add", 4'b0010, 32'd2, 32'd3,
        {32'd5, 1'b0, 1'b0});
    tick();

    // randomized traffic against the model
    sent = 0;
    cyc = 0;
    bad_bp = 1'b0;
    bad_stab = 1'b0;
    stalled = 1'b0;
    prev = '0;
    while ((sent < 150 || expq.size() > 0)
           && cyc < 20000) begin
      bus.in_valid = (sent < 150)
                  && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 11))
        0: rop = 4'b0000;
        1: rop = 4'b0001;
        2: rop = 4'b0010;
        3: rop = 4'b0110;
        4: rop = 4'b0111;
        5: rop = 4'b1000;
        6: rop = 4'b1001;
        7: rop = 4'b1010;
        8: rop = 4'b1100;
        9: rop = 4'b1011;
        default: rop = 4'($urandom);
      endcase
      bus.op = rop;
      case ($urandom_range(0, 3))
        0: bus.a = 32'h7FFF_FFFF;
        1: bus.a = 32'h8000_0000;
        default: bus.a = $urandom;
      endcase
      bus.b = ($urandom_range(0, 3) == 0)
            ? bus.a : $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled && obs_bus() !== prev)
        bad_stab = 1'b1;
      if (bus.out_valid && !bus.out_ready
          && bus.in_ready)
        bad_bp = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("rnd_spurious", 64'd1, 64'd0);
        end else begin
          exp_v = expq.pop_front();
          check("rnd_res", 64'(obs_bus()),
                64'(exp_v));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev = obs_bus();
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.op, bus.a, bus.b));
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("rnd_drain", 64'(expq.size()), 64'd0);
    check("rnd_sent", 64'(sent), 64'd150);
    check("rnd_bp_rule", 64'(bad_bp), 64'd0);
    check("rnd_stable", 64'(bad_stab), 64'd0);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
